hamming_alu: RTL and testbench
==============================

# hamming_alu

Parametrised successor to the search-loop ALU. It holds two WIDTH-bit operand registers and executes opcode-driven load, XOR, add and read operations in one cycle. It also runs a multi-cycle Hamming-distance operation, popcount(A ^ B), that tracks the best (lowest) distance seen. Operations use a valid/ready handshake, so the surrounding hash-search sequencer can stall on the multi-cycle path.

## Interface
Parameters:
- WIDTH, default 64: operand and result width. Must satisfy WIDTH >= CHUNK and WIDTH % CHUNK == 0.
- CHUNK, default 8: bits counted per cycle during DIST.
- CNT_W, derived as $clog2(WIDTH+1): width of the distance and best-score registers.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous and active-high.
- op_valid_i  in  1  opcode_i/operand_i are presented.
- op_ready_o  out  1  the block accepts an operation this cycle.
- opcode_i  in  4  operation select.
- operand_i  in  WIDTH  load data.
- result_o  out  WIDTH  last result; holds its value between results.
- result_valid_o  out  1  one-cycle pulse when result_o is new.
- best_o  out  CNT_W  lowest distance recorded.
- best_update_o  out  1  one-cycle pulse when best_o is lowered by DIST.

## Operation
- An operation is accepted on a rising edge where op_valid_i && op_ready_o.
- op_ready_o = (state == IDLE) && !rst_i.
- Opcodes (unlisted codes are accepted as NOP):
  - 0 NOP: no effect.
  - 1 LOAD_A: A <= operand_i.
  - 2 LOAD_B: B <= operand_i.
  - 3 XOR: A <= A ^ B; result_o <= A ^ B.
  - 4 ADD: A <= (A + B) mod 2^WIDTH; result_o <= the same value. The carry is discarded.
  - 5 DIST: snapshot X <= A ^ B, cnt <= 0, enter COUNT.
  - 6 LOAD_BEST: best <= operand_i[CNT_W-1:0].
  - 7 READ_A: result_o <= A.
  - 8 READ_BEST: result_o <= zero-extended best.
- XOR, ADD, READ_A, READ_BEST and DIST completion pulse result_valid_o. Loads and NOP do not.
- State machine:
  - IDLE -> COUNT on DIST accept.
  - COUNT: each edge, cnt += popcount(X[CHUNK-1:0]) and X >>= CHUNK.
  - COUNT -> IDLE after N = WIDTH/CHUNK chunks.
- Final COUNT edge:
  - result_o <= zero-extended final count; result_valid_o pulses.
  - If final count < best (strict): best <= final count and best_update_o pulses in the same cycle as result_valid_o.
  - If final count == best: best is kept and no update pulse occurs.
- A and B are not modified by DIST. The snapshot means later loads cannot corrupt the count.

## Timing
- Reset values: A = 0, B = 0, result_o = 0, result_valid_o = 0, best_o = WIDTH, best_update_o = 0, state IDLE, op_ready_o = 0 while rst_i is high.
- Single-cycle ops: results and register effects are visible the cycle after the accept edge.
- DIST: accept edge E0, chunks accumulated on edges E1..EN. result_valid_o is high in the cycle after EN, which is N cycles after acceptance; with defaults, 8 cycles.
- op_ready_o is low from the cycle after E0 through the cycle containing EN. It is high again in the cycle where result_valid_o is high, so back-to-back DISTs need no bubble.
- An operation presented while busy is not accepted. The producer holds it until ready; no queuing.
- The completion compare uses best as it was before the completion edge. LOAD_BEST cannot coincide with completion because ready is low.
- rst_i mid-COUNT aborts the count:
  - No result_valid_o or best_update_o is produced.
  - All registers take their reset values.
  - op_ready_o is high in the first cycle after rst_i deasserts.

## Structure
- Package hamming_alu_pkg holds:
  - opcode localparams (OP_NOP ... OP_READ_BEST);
  - state encoding (IDLE, COUNT);
  - a constant function for CNT_W.
- Sub-module hamming_counter owns X, cnt, the chunk counter and the COUNT FSM. It has a start/done interface plus a combinational CHUNK-bit popcount.
- The top level holds A, B, best, the result register, opcode decode and the handshake.

## Test plan
All scenarios use WIDTH = 64, CHUNK = 8.
1. Reset release:
   - Stimulus: hold rst_i for 2 cycles, then release.
   - Response: op_ready_o = 0 during reset and 1 after; result_o = 0; best_o = 64; no pulses.
2. Basic distance:
   - Stimulus: LOAD_A 0xFFFF0000FFFF0000, LOAD_B 0, DIST.
   - Response: 8 cycles later result_o = 32 with result_valid_o and best_update_o both pulsing; best_o = 32.
3. Add wrap and XOR:
   - Stimulus: A = 0xFFFFFFFFFFFFFFFF, B = 1, then ADD.
   - Response: result_o = 0.
   - Then XOR: result_o = 1, A = 1.
4. Busy stall:
   - Stimulus: DIST, then hold LOAD_A 0x5 with op_valid_i high.
   - Response: op_ready_o low for 8 cycles; the load is accepted in the result cycle; the DIST result is unaffected.
   - Then READ_A: result_o = 0x5.
5. Strict compare:
   - Stimulus: repeat scenario 2.
   - Response: result_o = 32 with no best_update_o.
   - Then LOAD_BEST 40 followed by DIST: best_update_o pulses and best_o = 32.
6. Reset mid-count:
   - Stimulus: assert rst_i at the 4th COUNT cycle.
   - Response: no result_valid_o; best_o = 64; A = B = 0; op_ready_o = 1 after release.

Source files
------------

// File: rtl/hamming_alu_pkg.sv
// Shared opcodes, counter FSM encoding and width helper for the Hamming-distance ALU.
package hamming_alu_pkg;

    localparam logic [3:0] OP_NOP       = 4'd0;
    localparam logic [3:0] OP_LOAD_A    = 4'd1;
    localparam logic [3:0] OP_LOAD_B    = 4'd2;
    localparam logic [3:0] OP_XOR       = 4'd3;
    localparam logic [3:0] OP_ADD       = 4'd4;
    localparam logic [3:0] OP_DIST      = 4'd5;
    localparam logic [3:0] OP_LOAD_BEST = 4'd6;
    localparam logic [3:0] OP_READ_A    = 4'd7;
    localparam logic [3:0] OP_READ_BEST = 4'd8;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    // Width needed to hold any distance from 0 up to and including width.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/hamming_counter.sv
// Multi-cycle popcount of a snapshot word, CHUNK bits per cycle.
// done is high during the last COUNT cycle; total is the final count in that cycle.
module hamming_counter
    import hamming_alu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CHUNK = 8,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x_in,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] total
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    state_t           state;
    logic [WIDTH-1:0] x;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] pop;
    logic [IDX_W-1:0] idx;

    // Popcount of the low chunk of the snapshot.
    always_comb begin
        // NOTE: pop gets a default before the loop so no latch is inferred; blocking '=' is right in combinational logic.
        pop = '0;
        for (int i = 0; i < CHUNK; i++) begin
            pop = pop + CNT_W'(x[i]);
        end
    end

    assign busy  = (state == COUNT);
    assign done  = busy && (idx == IDX_W'(N - 1));
    assign total = cnt + pop;

    // Snapshot on start, then accumulate one chunk per cycle until all N are counted.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking '<=' so every flop samples pre-edge values.
        if (rst) begin
            state <= IDLE;
            x     <= '0;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        x     <= x_in;
                        cnt   <= '0;
                        idx   <= '0;
                        state <= COUNT;
                    end
                end
                COUNT: begin
                    cnt <= total;
                    x   <= x >> CHUNK;
                    idx <= idx + 1'b1;
                    if (done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/hamming_alu.sv
// Two-operand ALU with load/XOR/add/read ops and a multi-cycle Hamming
// distance that tracks the lowest distance seen. Valid/ready handshake.
module hamming_alu
    import hamming_alu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CHUNK = 8,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             op_valid_i,
    output logic             op_ready_o,
    input  logic [3:0]       opcode_i,
    input  logic [WIDTH-1:0] operand_i,
    output logic [WIDTH-1:0] result_o,
    output logic             result_valid_o,
    output logic [CNT_W-1:0] best_o,
    output logic             best_update_o
);

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             accept;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] total;

    assign op_ready_o = !busy && !rst_i;
    assign accept     = op_valid_i && op_ready_o;
    assign sum        = a + b;
    assign diff       = a ^ b;

    hamming_counter #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK),
        .CNT_W (CNT_W)
    ) u_counter (
        .clk   (clk_i),
        .rst   (rst_i),
        .start (accept && (opcode_i == OP_DIST)),
        .x_in  (diff),
        .busy  (busy),
        .done  (done),
        .total (total)
    );

    // Opcode execution on accept, plus result and best-score update on count completion.
    // accept and done never coincide: accept needs IDLE, done needs COUNT.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a              <= '0;
            b              <= '0;
            result_o       <= '0;
            result_valid_o <= 1'b0;
            best_o         <= CNT_W'(WIDTH);
            best_update_o  <= 1'b0;
        end else begin
            result_valid_o <= 1'b0;
            best_update_o  <= 1'b0;
            if (accept) begin
                case (opcode_i)
                    OP_LOAD_A:    a <= operand_i;
                    OP_LOAD_B:    b <= operand_i;
                    OP_XOR: begin
                        a              <= diff;
                        result_o       <= diff;
                        result_valid_o <= 1'b1;
                    end
                    OP_ADD: begin
                        a              <= sum;
                        result_o       <= sum;
                        result_valid_o <= 1'b1;
                    end
                    OP_LOAD_BEST: best_o <= operand_i[CNT_W-1:0];
                    OP_READ_A: begin
                        result_o       <= a;
                        result_valid_o <= 1'b1;
                    end
                    OP_READ_BEST: begin
                        result_o       <= WIDTH'(best_o);
                        result_valid_o <= 1'b1;
                    end
                    default: ;
                endcase
            end
            if (done) begin
                result_o       <= WIDTH'(total);
                result_valid_o <= 1'b1;
                if (total < best_o) begin
                    best_o        <= total;
                    best_update_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_hamming_alu.sv
// Directed bench for hamming_alu (WIDTH=64, CHUNK=8) with a cycle-level
// behavioural model checked every cycle plus hand-computed expectations.
module tb_hamming_alu;
    import hamming_alu_pkg::*;

    localparam int WIDTH = 64;
    localparam int CHUNK = 8;
    localparam int N     = WIDTH / CHUNK;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        op_valid_i = 1'b0;
    logic        op_ready_o;
    logic [3:0]  opcode_i = 4'd0;
    logic [63:0] operand_i = '0;
    logic [63:0] result_o;
    logic        result_valid_o;
    logic [6:0]  best_o;
    logic        best_update_o;

    int checks   = 0;
    int failures = 0;

    hamming_alu #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .op_valid_i     (op_valid_i),
        .op_ready_o     (op_ready_o),
        .opcode_i       (opcode_i),
        .operand_i      (operand_i),
        .result_o       (result_o),
        .result_valid_o (result_valid_o),
        .best_o         (best_o),
        .best_update_o  (best_update_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: full-width popcount computed at accept, delivered after N cycles.
    logic [63:0] ma, mb, mres;
    logic [6:0]  mbest, mpend;
    logic        mval, mupd;
    int          mbusy = 0;
    bit          live = 0;

    always @(posedge clk_i) begin
        mval = 1'b0;
        mupd = 1'b0;
        if (rst_i) begin
            ma = '0; mb = '0; mres = '0; mbest = 7'd64; mbusy = 0; live = 1;
        end else if (mbusy > 0) begin
            mbusy--;
            if (mbusy == 0) begin
                mres = {57'd0, mpend};
                mval = 1'b1;
                if (mpend < mbest) begin
                    mbest = mpend;
                    mupd  = 1'b1;
                end
            end
        end else if (op_valid_i) begin
            case (opcode_i)
                4'd1: ma = operand_i;
                4'd2: mb = operand_i;
                4'd3: begin ma = ma ^ mb; mres = ma; mval = 1'b1; end
                4'd4: begin ma = ma + mb; mres = ma; mval = 1'b1; end
                4'd5: begin mpend = 7'($countones(ma ^ mb)); mbusy = N; end
                4'd6: mbest = operand_i[6:0];
                4'd7: begin mres = ma; mval = 1'b1; end
                4'd8: begin mres = {57'd0, mbest}; mval = 1'b1; end
                default: ;
            endcase
        end
    end

    // Every-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk_i) begin
        if (live) begin
            check("ready",       64'(op_ready_o),     64'((mbusy == 0) && !rst_i));
            check("result_valid", 64'(result_valid_o), 64'(mval));
            check("best_update", 64'(best_update_o),  64'(mupd));
            check("result",      result_o,            mres);
            check("best",        64'(best_o),         64'(mbest));
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    // Present an op, hold it until accepted (bounded), return wait cycles.
    task automatic do_op(input logic [3:0] op, input logic [63:0] data, output int waited);
        op_valid_i = 1'b1;
        opcode_i   = op;
        operand_i  = data;
        waited     = 0;
        while (!op_ready_o && waited < 100) begin
            tick();
            waited++;
        end
        if (waited >= 100) check("accept_timeout", 64'(waited), 64'd0);
        tick();
        op_valid_i = 1'b0;
        opcode_i   = OP_NOP;
    endtask

    initial begin
        int w;

        // 1. Reset release
        tick();
        check("s1_ready_in_reset", 64'(op_ready_o), 64'd0);
        tick();
        rst_i = 1'b0;
        #1;
        check("s1_ready_after", 64'(op_ready_o), 64'd1);
        check("s1_result", result_o, 64'd0);
        check("s1_best", 64'(best_o), 64'd64);
        check("s1_valid", 64'(result_valid_o), 64'd0);

        // 2. Basic distance
        do_op(OP_LOAD_A, 64'hFFFF0000FFFF0000, w);
        do_op(OP_LOAD_B, 64'h0, w);
        do_op(OP_DIST, 64'h0, w);
        repeat (N - 1) tick();
        check("s2_valid_early", 64'(result_valid_o), 64'd0);
        tick();
        check("s2_valid", 64'(result_valid_o), 64'd1);
        check("s2_result", result_o, 64'd32);
        check("s2_update", 64'(best_update_o), 64'd1);
        check("s2_best", 64'(best_o), 64'd32);
        check("s2_ready", 64'(op_ready_o), 64'd1);

        // 3. Add wrap and XOR
        do_op(OP_LOAD_A, 64'hFFFFFFFFFFFFFFFF, w);
        do_op(OP_LOAD_B, 64'h1, w);
        do_op(OP_ADD, 64'h0, w);
        check("s3_add", result_o, 64'd0);
        do_op(OP_XOR, 64'h0, w);
        check("s3_xor", result_o, 64'd1);
        do_op(OP_READ_A, 64'h0, w);
        check("s3_read_a", result_o, 64'd1);

        // 4. Busy stall (equal distance: no update)
        do_op(OP_LOAD_A, 64'hFFFF0000FFFF0000, w);
        do_op(OP_LOAD_B, 64'h0, w);
        do_op(OP_DIST, 64'h0, w);
        do_op(OP_LOAD_A, 64'h5, w);
        check("s4_wait", 64'(w), 64'(N));
        check("s4_result_held", result_o, 64'd32);
        check("s4_best", 64'(best_o), 64'd32);
        do_op(OP_READ_A, 64'h0, w);
        check("s4_read_a", result_o, 64'h5);

        // 5. Strict compare
        do_op(OP_LOAD_A, 64'hFFFF0000FFFF0000, w);
        do_op(OP_DIST, 64'h0, w);
        repeat (N) tick();
        check("s5_result", result_o, 64'd32);
        check("s5_no_update", 64'(best_update_o), 64'd0);
        do_op(OP_LOAD_BEST, 64'd40, w);
        do_op(OP_READ_BEST, 64'h0, w);
        check("s5_read_best", result_o, 64'd40);
        do_op(OP_DIST, 64'h0, w);
        repeat (N) tick();
        check("s5_update", 64'(best_update_o), 64'd1);
        check("s5_best", 64'(best_o), 64'd32);

        // Edge bits of first and last chunk, back-to-back DIST
        do_op(OP_LOAD_A, 64'h8000000000000001, w);
        do_op(OP_DIST, 64'h0, w);
        do_op(OP_DIST, 64'h0, w);
        check("edge_wait", 64'(w), 64'(N));
        check("edge_result", result_o, 64'd2);
        check("edge_best", 64'(best_o), 64'd2);
        repeat (N) tick();
        check("edge_equal_no_update", 64'(best_update_o), 64'd0);

        // 6. Reset mid-count
        do_op(OP_LOAD_B, 64'h00FF00FF00FF00FF, w);
        do_op(OP_DIST, 64'h0, w);
        repeat (3) tick();
        rst_i = 1'b1;
        repeat (2) tick();
        rst_i = 1'b0;
        #1;
        check("s6_ready", 64'(op_ready_o), 64'd1);
        check("s6_best", 64'(best_o), 64'd64);
        repeat (N) tick();
        check("s6_no_valid", 64'(result_valid_o), 64'd0);
        do_op(OP_READ_A, 64'h0, w);
        check("s6_a", result_o, 64'd0);
        do_op(OP_XOR, 64'h0, w);
        check("s6_b", result_o, 64'd0);
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
